carry_save_adder: RTL and testbench
===================================

Name: carry_save_adder

Overview:
Four-operand unsigned adder built as a carry-save (3:2 compressor) tree followed by a carry-propagate adder. It is pipelined: the CSA tree result is registered, then resolved by a ripple-carry adder into a registered result. It serves as a generic multi-operand accumulation primitive, for example for partial-product or checksum reduction.

Parameters:
WIDTH, 4, operand width in bits (≥2); result is WIDTH+2 bits, split into sum[WIDTH:0] and cout.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
valid_in  input  1  qualifies a, b, c and d this cycle
a  input  WIDTH  operand 0, unsigned
b  input  WIDTH  operand 1, unsigned
c  input  WIDTH  operand 2, unsigned
d  input  WIDTH  operand 3, unsigned
valid_out  output  1  sum/cout hold the result of the operands presented 2 cycles earlier
sum  output  WIDTH+1  low WIDTH+1 bits of a+b+c+d
cout  output  1  bit WIDTH+1 (MSB) of a+b+c+d

Behaviour:
- Arithmetic: {cout, sum} = a + b + c + d, exact and unsigned. The maximum is 4*(2^WIDTH-1), which fits in WIDTH+2 bits, so there is never overflow.
- Stage 0 (combinational, CSA level 1): 3:2 compress a, b and c into s1 (WIDTH) and c1 (WIDTH, weight shifted by 1).
- Stage 0 (combinational, CSA level 2): 3:2 compress s1, c1<<1 and d into s2 and c2, each WIDTH+2 bits zero-extended.
- Register stage 1: s2_q, c2_q and v1_q <= valid_in.
- Stage 1 (combinational): ripple-carry add of s2_q and c2_q<<1, truncated to WIDTH+2 bits.
- Register stage 2: {cout, sum} and valid_out <= v1_q.
- Latency: exactly 2 clk cycles from operands to outputs.
- Throughput: one new operand set per cycle, with no stalls and no backpressure.
- Datapath registers capture every cycle regardless of valid_in. Only the valid bits carry qualification.
- Reset (rst_n=0 at a rising edge): all pipeline registers clear. This means sum=0, cout=0 and valid_out=0 from the next cycle.
- Reset mid-operation: in-flight results are discarded. valid_out stays 0 until 2 cycles after the first valid_in sampled with rst_n=1.
- Reset has priority over capture on the same edge.
- Operands are never X-checked; X inputs propagate.
- No internal saturation or wrap: all widths are sized so the result is exact.

Decomposition:
- Package csa_pkg holds the default WIDTH and a function res_width(w) that returns w+2.
- Sub-module csa_full_adder is a 1-bit full adder (a, b, cin -> s, co).
- csa_full_adder is instantiated bitwise in both CSA levels and chained in the ripple-carry stage.
- No further hierarchy.

Test Plan:
- Reset, then a=0 b=0 c=0 d=0, valid_in=1 -> after 2 cycles: sum=00000, cout=0, valid_out=1.
- Back-to-back operand sets on consecutive cycles:
  - a=A b=3 c=5 d=4 -> sum=10110, cout=0 (22)
  - a=5 b=7 c=6 d=3 -> sum=10101, cout=0 (21)
  - a=3 b=9 c=A d=2 -> sum=11000, cout=0 (24)
  - Results must appear on three consecutive cycles.
- Carry-out cases:
  - a=A b=3 c=F d=8 -> sum=00100, cout=1 (36)
  - a=F b=F c=F d=F -> sum=11100, cout=1 (60, maximum)
- Valid gating: valid_in pattern 1,0,1 -> valid_out pattern 1,0,1 delayed by exactly 2 cycles.
- Reset mid-stream: assert rst_n=0 for 1 cycle while 2 results are in flight -> next cycle sum=0, cout=0, valid_out=0, and no stale result emerges afterwards.
- Randomized check with WIDTH=4 and WIDTH=8 over 1000 vectors against the reference model a+b+c+d, with a 2-cycle-delayed compare.

Source files
------------

// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared width parameters for the four-operand carry-save adder
package csa_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Four WIDTH-bit operands sum to at most 4*(2^w-1), which needs exactly w+2 bits.
  function automatic int res_width(input int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/csa_full_adder.sv
// rtl/csa_full_adder.sv - 1-bit full adder used as the 3:2 compressor cell and ripple cell
module csa_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/carry_save_adder.sv
// rtl/carry_save_adder.sv - two-stage pipelined four-operand unsigned adder (CSA tree + ripple CPA)
module carry_save_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             valid_out,
  output logic [WIDTH:0]   sum,
  output logic             cout
);

  localparam int RW = res_width(WIDTH);

  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_c1;
  logic [WIDTH:0]   w_l2_x;
  logic [WIDTH:0]   w_l2_y;
  logic [WIDTH:0]   w_l2_z;
  logic [WIDTH:0]   w_s2;
  logic [WIDTH:0]   w_c2;

  logic [WIDTH:0]   r_s2;
  logic [WIDTH:0]   r_c2;
  logic             r_v1;

  logic [RW-1:0]    w_p;
  logic [RW-1:0]    w_q;
  logic [RW-1:0]    w_rc;
  logic [RW-1:0]    w_res;

  logic [RW-1:0]    r_res;
  logic             r_v2;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lvl1
    csa_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .cin(c[i]),
      .s  (w_s1[i]),
      .co (w_c1[i])
    );
  end

  // Bit WIDTH+1 of all three level-2 inputs is zero, so only WIDTH+1 cells are needed.
  assign w_l2_x = {1'b0, w_s1};
  assign w_l2_y = {w_c1, 1'b0};
  assign w_l2_z = {1'b0, d};

  for (genvar i = 0; i <= WIDTH; i++) begin : g_lvl2
    csa_full_adder u_fa (
      .a  (w_l2_x[i]),
      .b  (w_l2_y[i]),
      .cin(w_l2_z[i]),
      .s  (w_s2[i]),
      .co (w_c2[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2 <= '0;
      r_c2 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_s2 <= w_s2;
      r_c2 <= w_c2;
      r_v1 <= valid_in;
    end
  end

  assign w_p     = {1'b0, r_s2};
  assign w_q     = {r_c2, 1'b0};
  assign w_rc[0] = 1'b0;

  for (genvar i = 0; i < RW - 1; i++) begin : g_cpa
    csa_full_adder u_fa (
      .a  (w_p[i]),
      .b  (w_q[i]),
      .cin(w_rc[i]),
      .s  (w_res[i]),
      .co (w_rc[i+1])
    );
  end

  // The result always fits in RW bits, so the MSB needs no carry-out.
  assign w_res[RW-1] = w_p[RW-1] ^ w_q[RW-1] ^ w_rc[RW-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res <= '0;
      r_v2  <= 1'b0;
    end else begin
      r_res <= w_res;
      r_v2  <= r_v1;
    end
  end

  assign sum       = r_res[WIDTH:0];
  assign cout      = r_res[RW-1];
  assign valid_out = r_v2;

endmodule

// File: tb/tb_carry_save_adder.sv
// tb/tb_carry_save_adder.sv - self-checking bench for carry_save_adder at WIDTH=4 and WIDTH=8
module tb_carry_save_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic [3:0] a4, b4, c4, d4;
  logic [4:0] sum4;
  logic       cout4, vout4;
  logic [7:0] a8, b8, c8, d8;
  logic [8:0] sum8;
  logic       cout8, vout8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  carry_save_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .a(a4), .b(b4), .c(c4), .d(d4),
    .valid_out(vout4), .sum(sum4), .cout(cout4)
  );

  carry_save_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .a(a8), .b(b8), .c(c8), .d(d8),
    .valid_out(vout8), .sum(sum8), .cout(cout8)
  );

  task automatic drive4(input logic v, input int ia, input int ib, input int ic, input int id);
    valid_in = v;
    a4 = 4'(ia); b4 = 4'(ib); c4 = 4'(ic); d4 = 4'(id);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    drive4(1'b1, 15, 15, 15, 15);
    repeat (2) @(negedge clk);
    total++;
    if ({cout4, sum4, vout4} !== 7'b0) begin
      bad++;
      $display("FAIL reset: cout=%b sum=%b valid=%b required 0 0 0", cout4, sum4, vout4);
    end
    rst_n = 1'b1;
    drive4(1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_zero;
    drive4(1'b1, 0, 0, 0, 0);
    @(negedge clk);
    drive4(1'b0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if ({vout4, cout4, sum4} !== {1'b1, 1'b0, 5'b00000}) begin
      bad++;
      $display("FAIL zero: valid=%b cout=%b sum=%b required 1 0 00000", vout4, cout4, sum4);
    end
  endtask

  task automatic test_back_to_back;
    int va[3] = '{10, 5, 3};
    int vb[3] = '{3, 7, 9};
    int vc[3] = '{5, 6, 10};
    int vd[3] = '{4, 3, 2};
    int ex[3] = '{22, 21, 24};
    for (int k = 0; k < 5; k++) begin
      if (k >= 2) begin
        total++;
        if ({vout4, cout4, sum4} !== {1'b1, 6'(ex[k-2])}) begin
          bad++;
          $display("FAIL back_to_back[%0d]: valid=%b result=%0d required valid=1 result=%0d",
                   k - 2, vout4, {cout4, sum4}, ex[k-2]);
        end
      end
      if (k < 3) drive4(1'b1, va[k], vb[k], vc[k], vd[k]);
      else drive4(1'b0, 0, 0, 0, 0);
      @(negedge clk);
    end
  endtask

  task automatic test_carry_out;
    int va[2] = '{10, 15};
    int vb[2] = '{3, 15};
    int vc[2] = '{15, 15};
    int vd[2] = '{8, 15};
    int ex[2] = '{36, 60};
    for (int k = 0; k < 2; k++) begin
      drive4(1'b1, va[k], vb[k], vc[k], vd[k]);
      @(negedge clk);
      drive4(1'b0, 0, 0, 0, 0);
      @(negedge clk);
      total++;
      if ({vout4, cout4, sum4} !== {1'b1, 6'(ex[k])}) begin
        bad++;
        $display("FAIL carry_out[%0d]: valid=%b cout=%b sum=%b required valid=1 value %0d",
                 k, vout4, cout4, sum4, ex[k]);
      end
    end
  endtask

  task automatic test_valid_gating;
    logic pat[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int   ex[6];
    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        total++;
        if (vout4 !== pat[k-2]) begin
          bad++;
          $display("FAIL valid_gating[%0d]: valid_out=%b required %b", k - 2, vout4, pat[k-2]);
        end
        if (pat[k-2]) begin
          total++;
          if ({cout4, sum4} !== 6'(ex[k-2])) begin
            bad++;
            $display("FAIL valid_gating_data[%0d]: result=%0d required %0d", k - 2, {cout4, sum4}, ex[k-2]);
          end
        end
      end
      begin
        int ia = $urandom_range(15), ib = $urandom_range(15);
        int ic = $urandom_range(15), id = $urandom_range(15);
        ex[k] = ia + ib + ic + id;
        drive4(pat[k], ia, ib, ic, id);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midstream;
    drive4(1'b1, 9, 9, 9, 9);
    @(negedge clk);
    drive4(1'b1, 1, 2, 3, 4);
    @(negedge clk);
    rst_n = 1'b0;
    drive4(1'b0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if ({vout4, cout4, sum4} !== 7'b0) begin
      bad++;
      $display("FAIL reset_mid: valid=%b cout=%b sum=%b required 0 0 00000", vout4, cout4, sum4);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (vout4 !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_stale[%0d]: valid_out=%b required 0", k, vout4);
      end
    end
  endtask

  task automatic test_random;
    int  e4_q[$];
    int  e8_q[$];
    bit  v_q[$];
    for (int n = 0; n < 1002; n++) begin
      if (v_q.size() == 2) begin
        bit ev = v_q.pop_front();
        int e4 = e4_q.pop_front();
        int e8 = e8_q.pop_front();
        total++;
        if (vout4 !== ev || vout8 !== ev) begin
          bad++;
          $display("FAIL random_valid[%0d]: w4=%b w8=%b required %b", n, vout4, vout8, ev);
        end
        if (ev) begin
          total++;
          if ({cout4, sum4} !== 6'(e4)) begin
            bad++;
            $display("FAIL random_w4[%0d]: result=%0d required %0d", n, {cout4, sum4}, e4);
          end
          total++;
          if ({cout8, sum8} !== 10'(e8)) begin
            bad++;
            $display("FAIL random_w8[%0d]: result=%0d required %0d", n, {cout8, sum8}, e8);
          end
        end
      end
      if (n < 1000) begin
        int x[4];
        int y[4];
        bit v = ($urandom_range(7) != 0);
        for (int j = 0; j < 4; j++) begin
          x[j] = (n % 50 == 0) ? 15 : $urandom_range(15);
          y[j] = (n % 50 == 1) ? 255 : $urandom_range(255);
        end
        drive4(v, x[0], x[1], x[2], x[3]);
        a8 = 8'(y[0]); b8 = 8'(y[1]); c8 = 8'(y[2]); d8 = 8'(y[3]);
        v_q.push_back(v);
        e4_q.push_back(x[0] + x[1] + x[2] + x[3]);
        e8_q.push_back(y[0] + y[1] + y[2] + y[3]);
      end else begin
        drive4(1'b0, 0, 0, 0, 0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    drive4(1'b0, 0, 0, 0, 0);
    a8 = '0; b8 = '0; c8 = '0; d8 = '0;
    test_reset;
    test_zero;
    test_back_to_back;
    test_carry_out;
    test_valid_gating;
    test_reset_midstream;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
